// File: rtl/accelerometer_spi_responder.sv
// -----------------------------------------------------------------------------
// accelerometer_spi_responder
//   SPI slave stand-in for the ADXL362 accelerometer on the Nexys 4 DDR board.
//   Decodes READ (0x0B) and WRITE (0x0A) commands. It serves a small register
//   map and returns Y/Z samples that are snapshotted on CS fall, so a burst
//   always sees one coherent pair. Every SPI input is oversampled by clk, so
//   clk must run at least 8x SCLK.
//
// Parameters
//   SYNC_STAGES  synchronizer depth for SCLK/CS/MOSI (>= 2)
//   DEVID        value returned at address 0x00
//   PARTID       value returned at address 0x02
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   SCLK       in   SPI clock (mode 0 timing)
//   CS         in   chip select, active low
//   MOSI       in   master-to-slave data, MSB first
//   MISO       out  slave-to-master data, MSB first
//   y_sample   in   live Y axis value (two's complement)
//   z_sample   in   live Z axis value (two's complement)
//   wr_strobe  out  one-clk pulse per completed write data byte
//   wr_addr    out  register address of that write
//   wr_data    out  byte written
//   cmd_error  out  one-clk pulse on an unknown command byte
//   xfer_done  out  one-clk pulse on CS rise after >= 1 complete data byte
// -----------------------------------------------------------------------------
module accelerometer_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hAD,
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               SCLK,
  input  logic               CS,
  input  logic               MOSI,
  output logic               MISO,
  input  logic signed [15:0] y_sample,
  input  logic signed [15:0] z_sample,
  output logic               wr_strobe,
  output logic [5:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               cmd_error,
  output logic               xfer_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA, S_IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic                   w_sclk, w_cs, w_mosi;
  logic                   w_sclk_rise, w_sclk_fall, w_cs_fall;

  logic [2:0]  r_bit_cnt;
  logic [2:0]  r_fall_cnt;
  logic [6:0]  r_shift;
  logic        r_is_read;
  logic [5:0]  r_addr;
  logic        r_got_byte;
  logic        r_miso;
  logic [31:0] r_shadow;
  logic [7:0]  r_ram [16];
  logic        r_wr_strobe, r_cmd_error, r_xfer_done;
  logic [5:0]  r_wr_addr;
  logic [7:0]  r_wr_data;

  logic [7:0]  w_byte;
  logic [7:0]  w_rd_byte;
  logic        w_cmd_ok;
  logic        w_start, w_abort, w_shift, w_byte_end;
  logic        w_cmd_bad, w_wr_fire, w_rd_fall, w_rd_byte_end;

  // ---- input synchronizers and edge detect ----
  // CS chain resets low so that a CS already held low when reset releases
  // does not look like a fresh falling edge; only a real high->low starts a
  // transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;

  assign w_byte   = {r_shift, w_mosi};
  assign w_cmd_ok = (w_byte == CMD_READ) || (w_byte == CMD_WRITE);

  // ---- FSM state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---- FSM next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) w_state_nxt = S_CMD;
        S_CMD:   if (w_byte_end) w_state_nxt = w_cmd_ok ? S_ADDR : S_IGNORE;
        S_ADDR:  if (w_byte_end) w_state_nxt = r_is_read ? S_RD_DATA : S_WR_DATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // ---- FSM output decode (datapath strobes) ----
  // Rising edges only count in the shifting states, so a falling SCLK before
  // the first rise of a transfer has no effect anywhere.
  always_comb begin
    w_start       = (r_state == S_IDLE) && w_cs_fall;
    w_abort       = (r_state != S_IDLE) && w_cs;
    w_shift       = 1'b0;
    case (r_state)
      S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA: w_shift = w_sclk_rise && !w_cs;
      default:                             w_shift = 1'b0;
    endcase
    w_byte_end    = w_shift && (r_bit_cnt == 3'd7);
    w_cmd_bad     = (r_state == S_CMD) && w_byte_end && !w_cmd_ok;
    w_wr_fire     = (r_state == S_WR_DATA) && w_byte_end;
    w_rd_byte_end = (r_state == S_RD_DATA) && w_byte_end;
    w_rd_fall     = (r_state == S_RD_DATA) && w_sclk_fall && !w_cs;
  end

  // ---- register map read mux ----
  always_comb begin
    w_rd_byte = 8'h00;
    case (r_addr)
      6'h00:   w_rd_byte = DEVID;
      6'h01:   w_rd_byte = 8'h1D;
      6'h02:   w_rd_byte = PARTID;
      6'h10:   w_rd_byte = r_shadow[7:0];
      6'h11:   w_rd_byte = r_shadow[15:8];
      6'h12:   w_rd_byte = r_shadow[23:16];
      6'h13:   w_rd_byte = r_shadow[31:24];
      default: if (r_addr[5:4] == 2'b10) w_rd_byte = r_ram[r_addr[3:0]];
    endcase
  end

  // ---- data-only registers: shift register and sample shadow ----
  always_ff @(posedge clk) begin
    if (w_shift) r_shift  <= w_byte[6:0];
    if (w_start) r_shadow <= {z_sample, y_sample};
  end

  // ---- control, address, MISO and output pulses ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_fall_cnt  <= '0;
      r_is_read   <= 1'b0;
      r_addr      <= '0;
      r_got_byte  <= 1'b0;
      r_miso      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cmd_error <= 1'b0;
      r_xfer_done <= 1'b0;
      for (int i = 0; i < 16; i++) r_ram[i] <= 8'h00;
    end else begin
      r_wr_strobe <= 1'b0;
      r_cmd_error <= 1'b0;
      r_xfer_done <= 1'b0;

      if (w_start) begin
        r_bit_cnt  <= '0;
        r_fall_cnt <= '0;
        r_got_byte <= 1'b0;
      end

      if (w_shift) r_bit_cnt <= r_bit_cnt + 3'd1;

      if ((r_state == S_CMD) && w_byte_end) r_is_read <= (w_byte == CMD_READ);
      if ((r_state == S_ADDR) && w_byte_end) r_addr <= w_byte[5:0];
      if (w_cmd_bad) r_cmd_error <= 1'b1;

      if (w_wr_fire) begin
        r_wr_strobe <= 1'b1;
        r_wr_addr   <= r_addr;
        r_wr_data   <= w_byte;
        if (r_addr[5:4] == 2'b10) r_ram[r_addr[3:0]] <= w_byte;
        r_addr      <= r_addr + 6'd1;
        r_got_byte  <= 1'b1;
      end

      if (w_rd_byte_end) r_got_byte <= 1'b1;

      // Eight falls present bits 7..0; the eighth also advances the address so
      // the ninth fall starts the next byte without a gap.
      if (w_rd_fall) begin
        r_miso     <= w_rd_byte[3'd7 - r_fall_cnt];
        r_fall_cnt <= r_fall_cnt + 3'd1;
        if (r_fall_cnt == 3'd7) r_addr <= r_addr + 6'd1;
      end

      if (w_abort) begin
        r_miso      <= 1'b0;
        r_xfer_done <= r_got_byte;
        r_got_byte  <= 1'b0;
      end
    end
  end

  assign MISO      = r_miso;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign cmd_error = r_cmd_error;
  assign xfer_done = r_xfer_done;

endmodule
